// File: rtl/fdc_sector_sequencer.sv
// Single-sector transfer sequencer between the FDC command core and the host
// disk-image service, with one sector buffer and a host-stall timeout.
module fdc_sector_sequencer #(
  parameter int SECTOR_BYTES = 512,
  parameter int TIMEOUT      = 4000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic        req_drive,
  input  logic        req_side,
  input  logic [6:0]  req_track,
  input  logic [7:0]  req_sector,
  output logic        req_ready,
  input  logic        fdc_rd_strobe,
  output logic [7:0]  fdc_rd_data,
  input  logic        fdc_wr_strobe,
  input  logic [7:0]  fdc_wr_data,
  output logic        done,
  output logic        error,
  output logic [31:0] disk_sr,
  input  logic [31:0] disk_cr,
  input  logic [7:0]  disk_data_in,
  input  logic        disk_data_clkin,
  output logic [7:0]  disk_data_out,
  input  logic        disk_data_clkout
);

  localparam int AW = $clog2(SECTOR_BYTES);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] LAST = PW'(SECTOR_BYTES - 1);
  localparam logic [23:0]   TERM = 24'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, RD_REQ, RD_FILL, RD_SERVE, WR_COLLECT, WR_REQ, WR_DRAIN, ACK_LOW, FAIL
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [23:0]   timer, timer_n;
  logic          lat_write, lat_drive, lat_side;
  logic [6:0]    lat_track;
  logic [7:0]    lat_sector;
  logic          ack_armed;
  logic          clkin_q, clkout_q;
  logic          clkin_rise, clkout_rise;
  logic          latch, accept_ack, timed, timeout;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic          sr_req;
  logic          ack, host_err;
  logic          unused_cr;

  logic [7:0] sector_mem [SECTOR_BYTES];

  assign ack         = disk_cr[31];
  assign host_err    = disk_cr[30];
  assign unused_cr   = ^disk_cr[29:0];
  assign clkin_rise  = disk_data_clkin & ~clkin_q;
  assign clkout_rise = disk_data_clkout & ~clkout_q;

  assign sr_req    = (state inside {RD_REQ, RD_FILL, WR_REQ, WR_DRAIN});
  assign req_ready = (state == IDLE);
  assign disk_sr   = {sr_req, lat_write, lat_drive, lat_side, lat_track, lat_sector, 13'b0};

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    timer_n    = timer;
    latch      = 1'b0;
    accept_ack = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = 8'h00;
    timed      = (state inside {RD_REQ, RD_FILL, WR_REQ, WR_DRAIN, ACK_LOW});
    timeout    = timed && (timer == TERM);
    if (timed) timer_n = timer + 24'd1;

    case (state)
      IDLE: begin
        if (req_valid) begin
          latch   = 1'b1;
          ptr_n   = '0;
          state_n = req_write ? WR_COLLECT : RD_REQ;
        end
      end
      RD_REQ: begin
        if (ack && ack_armed) begin
          accept_ack = 1'b1;
          state_n    = host_err ? FAIL : RD_FILL;
        end else if (timeout) begin
          state_n = FAIL;
        end
      end
      // A byte edge wins over the terminal count and restarts the timer.
      RD_FILL: begin
        if (clkin_rise) begin
          mem_we    = 1'b1;
          mem_wdata = disk_data_in;
          timer_n   = '0;
          if (ptr == LAST) begin
            ptr_n   = '0;
            state_n = RD_SERVE;
          end else begin
            ptr_n = ptr + 1'b1;
          end
        end else if (timeout) begin
          state_n = FAIL;
        end
      end
      RD_SERVE: begin
        if (fdc_rd_strobe) begin
          ptr_n = ptr + 1'b1;
          if (ptr == LAST) state_n = ACK_LOW;
        end
      end
      WR_COLLECT: begin
        if (fdc_wr_strobe) begin
          mem_we    = 1'b1;
          mem_wdata = fdc_wr_data;
          if (ptr == LAST) begin
            ptr_n   = '0;
            state_n = WR_REQ;
          end else begin
            ptr_n = ptr + 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (ack && ack_armed) begin
          accept_ack = 1'b1;
          state_n    = host_err ? FAIL : WR_DRAIN;
        end else if (timeout) begin
          state_n = FAIL;
        end
      end
      WR_DRAIN: begin
        if (clkout_rise) begin
          timer_n = '0;
          ptr_n   = ptr + 1'b1;
          if (ptr == LAST) state_n = ACK_LOW;
        end else if (timeout) begin
          state_n = FAIL;
        end
      end
      ACK_LOW: begin
        if (!ack) state_n = IDLE;
        else if (timeout) state_n = FAIL;
      end
      FAIL:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (state_n != state) timer_n = '0;
  end

  always_ff @(posedge clk) begin
    if (mem_we) sector_mem[ptr[AW-1:0]] <= mem_wdata;
  end

  // An ack still high from the previous transfer must be seen low before
  // the next request may consume it.
  always_ff @(posedge clk) begin
    clkin_q  <= disk_data_clkin;
    clkout_q <= disk_data_clkout;
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      timer         <= '0;
      lat_write     <= 1'b0;
      lat_drive     <= 1'b0;
      lat_side      <= 1'b0;
      lat_track     <= '0;
      lat_sector    <= '0;
      ack_armed     <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      fdc_rd_data   <= '0;
      disk_data_out <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      timer <= timer_n;
      if (latch) begin
        lat_write  <= req_write;
        lat_drive  <= req_drive;
        lat_side   <= req_side;
        lat_track  <= req_track;
        lat_sector <= req_sector;
      end
      if (!ack) ack_armed <= 1'b1;
      else if (accept_ack || state_n == FAIL) ack_armed <= 1'b0;
      done  <= (state == ACK_LOW) && (state_n == IDLE);
      error <= (state_n == FAIL);
      if (state == RD_SERVE) fdc_rd_data <= sector_mem[ptr[AW-1:0]];
      if (state == WR_DRAIN) disk_data_out <= sector_mem[ptr[AW-1:0]];
    end
  end

endmodule
